genius_seq_player: RTL
======================

# genius_seq_player

Playback stage directly downstream of the 64-bit sequence register in the Genius game. On `start`, it captures the stored colour sequence and the current level, then plays the first `level` colour nibbles on the four LEDs. Nibbles are played most-significant first, one at a time, each lit for a fixed on-time followed by a fixed dark gap. It then pulses `done` so the game controller can hand over to player input.

## Interface
- `N`, 64, sequence word width in bits; must be a multiple of 4; holds `N/4` steps.
- `ON_CYCLES`, 25_000_000, clock cycles each step is lit; must be ≥ 1.
- `OFF_CYCLES`, 12_500_000, dark clock cycles after each step; must be ≥ 1.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `R`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin playback; sampled only in IDLE.
- `level`  in  5  number of steps to play; 0..`N/4`.
- `seq`  in  N  colour sequence; step k is `seq[N-1-4k : N-4-4k]`.
- `leds`  out  4  LED drive; shows the current step's nibble during ON, otherwise 0.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of playback.
- `step`  out  4  index of the step currently being played; 0 when idle.

## Operation
- Reset values, applied while `R`=1 at a clock edge, take priority over everything else:
  - state = IDLE.
  - `leds` = 0, `busy` = 0, `done` = 0, `step` = 0.
  - Internal shadow register and timer = 0.
- States: IDLE, ON, OFF, DONE.
- IDLE:
  - If `start`=1:
    - Capture `seq` into a shadow register.
    - Capture `level`, clamped to `N/4` when larger.
    - Clear the timer and set `step` = 0.
    - Go to ON if the clamped level ≥ 1; go to DONE if it is 0.
  - Otherwise remain in IDLE.
- ON:
  - `leds` = shadow nibble [`step`]. The nibble is driven as-is; no one-hot check is performed.
  - The timer counts up; after `ON_CYCLES` cycles, clear the timer and go to OFF.
- OFF:
  - `leds` = 0.
  - After `OFF_CYCLES` cycles, clear the timer. Then:
    - If `step` = level−1, go to DONE.
    - Otherwise increment `step` and go to ON.
- DONE:
  - `done` = 1 for exactly this one cycle.
  - `leds` = 0 and `step` = 0.
  - Next state is IDLE.
- Boundary conditions:
  - `start` is ignored outside IDLE, including in DONE.
  - Changes to `seq` and `level` during playback have no effect; only the shadow copies are used.
  - Level `N/4` plays every nibble, down to the lowest.
  - `R` asserted mid-playback returns the block to reset values at the next edge. LEDs go dark and no `done` pulse is issued.
- Timer width is ceil(log2(max(ON_CYCLES, OFF_CYCLES)+1)) bits. The timer never wraps, because it is cleared at each state exit.
- All outputs are registered: each one is a function of the current state only, never of the current inputs.

## Timing
- Let `start` be sampled at edge 0 and L = clamped level ≥ 1.
- Step k:
  - Lit from cycle 1 + k·(ON+OFF) for `ON_CYCLES` cycles.
  - Dark for the following `OFF_CYCLES` cycles.
- `done` is high during cycle 1 + L·(ON+OFF).
- The block is back in IDLE the cycle after `done`.
- The earliest accepted restart is sampled on the edge that ends that IDLE cycle.
- L = 0: `done` is high in cycle 1 and `leds` never light.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- Total playback length is 1 + L·(ON+OFF) cycles, plus one cycle of DONE.

## Test plan
- Reset: hold `R`=1 for 2 cycles with `start`=1.
  - Required: `leds`=0, `busy`=0, `done`=0, `step`=0 throughout.
  - Required: after release, the block stays idle until a new `start`.
- Basic playback: ON=3, OFF=2, `seq`=0x8421_0000_0000_0000, `level`=3, `start` pulsed at edge 0.
  - Required: `leds` = 8 in cycles 1–3, 0 in cycles 4–5, 4 in cycles 6–8, 2 in cycles 11–13.
  - Required: `done`=1 only in cycle 16.
- Level 0 and clamp:
  - `level`=0 → `done` in cycle 1, `leds` stays 0.
  - `level`=20 with `seq`=all-0x1 → 16 lit steps, then `done` in cycle 81.
- Input isolation:
  - Change `seq` to 0 and pulse `start` during step 1 of the basic run.
  - Required: the sequence still plays 8, 4, 2 with unchanged timing.
- Reset mid-play: assert `R` in cycle 7 of the basic run.
  - Required: `leds`=0, `busy`=0 and `step`=0 from cycle 8.
  - Required: no `done` pulse, and a new `start` replays from step 0.
- Back-to-back: hold `start`=1 continuously with `level`=1.
  - Required: `done` in cycle 6.
  - Required: the restart is sampled at the end of cycle 7, so step 0 lights again in cycle 8.

Source files
------------

// File: rtl/genius_seq_player.sv
// Genius game playback stage: replays the first `level` colour nibbles
// of a captured sequence on the LEDs, MSB first, then pulses done.
module genius_seq_player #(
  parameter int N          = 64,
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000
) (
  input  logic         CLK,
  input  logic         R,
  input  logic         start,
  input  logic [4:0]   level,
  input  logic [N-1:0] seq,
  output logic [3:0]   leds,
  output logic         busy,
  output logic         done,
  output logic [3:0]   step
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ?
                        ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [4:0]    STEPS    = 5'(N / 4);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic [4:0]     lvl_q, lvl_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [3:0]     step_q, step_d;
  logic [3:0]     leds_q, leds_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   shifted;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    lvl_d    = lvl_q;
    timer_d  = timer_q;
    step_d   = step_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = seq;
          lvl_d    = (level > STEPS) ? STEPS : level;
          timer_d  = '0;
          step_d   = '0;
          state_d  = (lvl_d != 5'd0) ? ON : DONE;
        end
      end
      ON: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = OFF;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if ({1'b0, step_q} == lvl_q - 5'd1) begin
            step_d  = '0;
            state_d = DONE;
          end else begin
            step_d  = step_q + 4'd1;
            state_d = ON;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        step_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state_q.
  always_comb begin
    shifted = shadow_d << {step_d, 2'b00};
    leds_d  = (state_d == ON) ? shifted[N-1 -: 4] : 4'd0;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      lvl_q    <= '0;
      timer_q  <= '0;
      step_q   <= '0;
      leds_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      lvl_q    <= lvl_d;
      timer_q  <= timer_d;
      step_q   <= step_d;
      leds_q   <= leds_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign leds = leds_q;
  assign busy = busy_q;
  assign done = done_q;
  assign step = step_q;

endmodule
